// File: rtl/viterbi_pkg.sv
// Shared Viterbi definitions: trellis sizing, the traceback FSM state
// encoding, and the trellis helper functions used by the traceback logic.
//
// Trellis convention: a step moves s -> ns = {u, s[M-1:1]}; the survivor
// decision d selects the predecessor ps = {ns[M-2:0], d}, and the bit
// decoded on that step is the MSB of ns.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int M          = K - 1;
  localparam int NUM_STATES = 1 << M;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    TRACE  = 2'd1,
    OUTPUT = 2'd2
  } tb_state_t;

  // Predecessor of trellis state ns given its survivor decision d.
  function automatic logic [M-1:0] pred_state(input logic [M-1:0] ns, input logic d);
    return {ns[M-2:0], d};
  endfunction

  // Input bit that led into trellis state ns.
  function automatic logic decoded_bit(input logic [M-1:0] ns);
    return ns[M-1];
  endfunction

endpackage

// File: rtl/tb_survivor_mem.sv
// Survivor memory: FRAME_LEN entries of NUM_STATES decision bits.
// Ports: clk; wr_en/wr_addr/wr_data single write port (rising edge);
// rd_addr/rd_data combinational read port.
// Contents are not reset; every entry is rewritten before it is read.
module tb_survivor_mem
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int PW        = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [PW-1:0]         wr_addr,
  input  logic [NUM_STATES-1:0] wr_data,
  input  logic [PW-1:0]         rd_addr,
  output logic [NUM_STATES-1:0] rd_data
);

  logic [NUM_STATES-1:0] mem [FRAME_LEN];

  // Write one decision vector per accepted beat.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/traceback_unit.sv
// Viterbi survivor-memory and traceback stage.
// Stores one decision vector per trellis step (FILL), traces back from
// best_state over FRAME_LEN cycles (TRACE), then streams the decoded bits
// oldest-first over a valid/ready handshake (OUTPUT).
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   dec_in/dec_valid/dec_ready   decision vector input handshake
//   best_state        start state, sampled with a frame's last decision
//   bit_out/bit_valid/bit_ready/bit_last   decoded bit output handshake
module traceback_unit
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STATES-1:0] dec_in,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [M-1:0]          best_state,
  output logic                  bit_out,
  output logic                  bit_valid,
  input  logic                  bit_ready,
  output logic                  bit_last
);

  localparam int            PW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] ZERO_IDX = PW'(0);
  localparam logic [PW-1:0] ONE_IDX  = PW'(1);

  tb_state_t             state;
  tb_state_t             next_state;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         out_ptr;
  logic [PW-1:0]         out_nxt;
  logic [M-1:0]          cur_state;
  logic [FRAME_LEN-1:0]  bitbuf;
  logic [NUM_STATES-1:0] rd_data;
  logic                  wr_en;
  logic                  fill_done;
  logic                  trace_done;
  logic                  out_fire;
  logic                  out_done;
  logic                  trace_d;

  assign wr_en      = (state == FILL) & dec_valid & dec_ready;
  assign fill_done  = wr_en & (wr_ptr == LAST_IDX);
  assign trace_done = (state == TRACE) & (rd_ptr == ZERO_IDX);
  assign out_fire   = (state == OUTPUT) & bit_valid & bit_ready;
  // bit_last is kept equal to bit_valid & (out_ptr == LAST_IDX)
  assign out_done   = out_fire & bit_last;
  assign out_nxt    = out_ptr + ONE_IDX;
  assign trace_d    = rd_data[cur_state];

  tb_survivor_mem #(
    .FRAME_LEN (FRAME_LEN),
    .PW        (PW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (dec_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      FILL: begin
        if (fill_done) begin
          next_state = TRACE;
        end else begin
          next_state = FILL;
        end
      end
      TRACE: begin
        if (trace_done) begin
          next_state = OUTPUT;
        end else begin
          next_state = TRACE;
        end
      end
      OUTPUT: begin
        if (out_done) begin
          next_state = FILL;
        end else begin
          next_state = OUTPUT;
        end
      end
      default: next_state = FILL;
    endcase
  end

  // Pointers, traceback state, bit buffer and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= ZERO_IDX;
      rd_ptr    <= ZERO_IDX;
      out_ptr   <= ZERO_IDX;
      cur_state <= {M{1'b0}};
      bitbuf    <= {FRAME_LEN{1'b0}};
      dec_ready <= 1'b0;
      bit_valid <= 1'b0;
      bit_last  <= 1'b0;
      bit_out   <= 1'b0;
    end else begin
      // Input is accepted exactly when the FSM will sit in FILL next cycle.
      dec_ready <= (next_state == FILL);
      case (state)
        FILL: begin
          if (fill_done) begin
            wr_ptr    <= ZERO_IDX;
            cur_state <= best_state;
            rd_ptr    <= LAST_IDX;
          end else if (wr_en) begin
            wr_ptr <= wr_ptr + ONE_IDX;
          end else begin
            wr_ptr <= wr_ptr;
          end
        end
        TRACE: begin
          bitbuf[rd_ptr] <= decoded_bit(cur_state);
          cur_state      <= pred_state(cur_state, trace_d);
          if (rd_ptr == ZERO_IDX) begin
            // bitbuf[0] is being written this edge, so forward it directly.
            out_ptr   <= ZERO_IDX;
            bit_valid <= 1'b1;
            bit_out   <= decoded_bit(cur_state);
            bit_last  <= 1'b0;
          end else begin
            rd_ptr <= rd_ptr - ONE_IDX;
          end
        end
        OUTPUT: begin
          if (out_done) begin
            out_ptr   <= ZERO_IDX;
            wr_ptr    <= ZERO_IDX;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
          end else if (out_fire) begin
            out_ptr  <= out_nxt;
            bit_out  <= bitbuf[out_nxt];
            bit_last <= (out_nxt == LAST_IDX);
          end else begin
            out_ptr <= out_ptr;
          end
        end
        default: begin
          bit_valid <= 1'b0;
          bit_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed self-checking bench for traceback_unit (FRAME_LEN = 8, K = 3).
module tb_traceback_unit;

  logic       clk;
  logic       rst;
  logic [3:0] dec_in;
  logic       dec_valid;
  logic       dec_ready;
  logic [1:0] best_state;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       bit_last;

  int n_checks = 0;
  int n_errors = 0;
  bit junk     = 1'b0;

  // steps 0..7 = 0000,0000,0100,0000,0010,0001,0000,0000 (step i at [4i+:4])
  localparam logic [31:0] KNOWN     = 32'h0012_0400;
  // decoded bits 1,0,1,1,0,0,1,0 (bit i at [i])
  localparam logic [7:0]  KNOWN_EXP = 8'h4D;

  traceback_unit #(.FRAME_LEN(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dec_in     (dec_in),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .best_state (best_state),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .bit_last   (bit_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; optionally keeps hammering the input with junk beats.
  task automatic tick();
    if (junk) begin
      dec_valid = 1'b1;
      dec_in    = 4'($urandom);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string tag, input logic [31:0] frame,
                            input logic [1:0] bs, input bit gapped);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < 8 && guard < 100) begin
      if (gapped && (guard % 2 == 1)) begin
        dec_valid  = 1'b0;
        dec_in     = 4'hF;
        best_state = ~bs;
      end else begin
        dec_valid  = 1'b1;
        dec_in     = frame[i*4 +: 4];
        best_state = (i == 7) ? bs : ~bs;
      end
      acc = dec_valid & dec_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    dec_valid = 1'b0;
    check({tag, "_accepted"}, i, 8);
  endtask

  task automatic recv_frame(input string tag, input logic [7:0] exp_bits,
                            input int stall_idx, input int stall_len);
    int idx = 0;
    int stall = 0;
    int cyc = 0;
    while (idx < 8 && cyc < 100) begin
      bit fire;
      check({tag, "_busy_ready"}, dec_ready, 0);
      check({tag, "_valid"}, bit_valid, 1);
      check({tag, "_bit"}, bit_out, exp_bits[idx]);
      check({tag, "_last"}, bit_last, (idx == 7));
      if (idx == stall_idx && stall < stall_len) begin
        bit_ready = 1'b0;
        stall++;
      end else begin
        bit_ready = 1'b1;
      end
      fire = bit_valid & bit_ready;
      tick();
      if (fire) idx++;
      cyc++;
    end
    junk      = 1'b0;
    dec_valid = 1'b0;
    bit_ready = 1'b1;
    check({tag, "_handshakes"}, idx, 8);
    check({tag, "_valid_drop"}, bit_valid, 0);
    check({tag, "_ready_back"}, dec_ready, 1);
  endtask

  task automatic run_frame(input string tag, input logic [31:0] frame, input logic [1:0] bs,
                           input logic [7:0] exp_bits, input bit gapped,
                           input int stall_idx, input int stall_len, input bit junk_en);
    int n = 0;
    send_frame(tag, frame, bs, gapped);
    check({tag, "_ready_drop"}, dec_ready, 0);
    junk = junk_en;
    while (!bit_valid && n < 50) begin
      check({tag, "_trace_ready"}, dec_ready, 0);
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 8);
    recv_frame(tag, exp_bits, stall_idx, stall_len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    dec_valid  = 1'b0;
    dec_in     = 4'h0;
    best_state = 2'b00;
    bit_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dec_ready", dec_ready, 0);
    check("rst_bit_valid", bit_valid, 0);
    check("rst_bit_last", bit_last, 0);
    rst = 1'b1;
    check("release_ready", dec_ready, 0);
    @(posedge clk);
    #1;
    check("first_edge_ready", dec_ready, 1);

    run_frame("zero", 32'h0000_0000, 2'b00, 8'h00, 1'b0, -1, 0, 1'b0);
    run_frame("known", KNOWN, 2'b01, KNOWN_EXP, 1'b0, -1, 0, 1'b0);
    run_frame("bp", KNOWN, 2'b01, KNOWN_EXP, 1'b0, 3, 3, 1'b0);
    run_frame("junk", KNOWN, 2'b01, KNOWN_EXP, 1'b0, -1, 0, 1'b1);
    run_frame("after_junk", KNOWN, 2'b01, KNOWN_EXP, 1'b0, -1, 0, 1'b0);
    run_frame("gap", KNOWN, 2'b01, KNOWN_EXP, 1'b1, -1, 0, 1'b0);

    // Reset in the middle of traceback.
    send_frame("midrst", KNOWN, 2'b01, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", dec_ready, 0);
    check("midrst_valid", bit_valid, 0);
    check("midrst_last", bit_last, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("midrst_release_ready", dec_ready, 0);
    @(posedge clk);
    #1;
    check("midrst_edge_ready", dec_ready, 1);
    for (int i = 0; i < 12; i++) begin
      check("midrst_no_bits", bit_valid, 0);
      @(posedge clk);
      #1;
    end
    run_frame("post_rst", 32'h0000_0000, 2'b00, 8'h00, 1'b0, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
